// File: rtl/prim_key_event_pkg.sv
// Shared types for the key event detector: FSM state encoding and status bit positions.
package prim_key_event_pkg;

  typedef enum logic [1:0] {
    KeyDisarmed = 2'd0,
    KeyIdle     = 2'd1,
    KeyPressed  = 2'd2,
    KeyHeld     = 2'd3
  } key_state_e;

  localparam int unsigned StPress   = 0;
  localparam int unsigned StRelease = 1;
  localparam int unsigned StHold    = 2;

endpackage

// File: rtl/prim_sat_counter.sv
// Width-bit up counter with synchronous clear and saturation at all-ones.
// cnt_inc_o exposes the saturated next value so callers can compare ahead of the edge.
module prim_sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o,
  output logic [Width-1:0] cnt_inc_o
);

  logic [Width-1:0] cnt_q;

  assign cnt_inc_o = (&cnt_q) ? cnt_q : cnt_q + Width'(1);
  assign cnt_o     = cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_inc_o;
    end
  end

endmodule

// File: rtl/prim_key_event_detect.sv
// Turns a filtered key level into press/release/hold pulses, a pressed level
// and sticky status bits.
//
//   state       | meaning
//   KeyDisarmed | disabled, or waiting for an inactive level before arming
//   KeyIdle     | armed, key released
//   KeyPressed  | key down, hold threshold not yet reached
//   KeyHeld     | key down, hold event already issued
module prim_key_event_detect
  import prim_key_event_pkg::*;
#(
  parameter int unsigned CntW       = 16,
  parameter bit          ActiveHigh = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            enable_i,
  input  logic            level_i,
  input  logic [CntW-1:0] hold_thresh_i,
  input  logic [2:0]      status_clr_i,
  output logic            press_o,
  output logic            release_o,
  output logic            hold_o,
  output logic            pressed_o,
  output logic [CntW-1:0] hold_cnt_o,
  output logic [2:0]      status_o
);

  key_state_e      state_q, state_d;
  logic            act;
  logic            down;
  logic            ev_press, ev_release, ev_hold;
  logic            cnt_inc_en;
  logic [CntW-1:0] cnt_inc;
  logic [2:0]      status_set;

  assign act  = ActiveHigh ? level_i : ~level_i;
  assign down = enable_i && ((state_q == KeyPressed) || (state_q == KeyHeld));

  assign ev_press   = enable_i && (state_q == KeyIdle) && act;
  assign ev_release = down && !act;
  // Release wins over hold because ev_hold requires act still high.
  assign ev_hold    = enable_i && (state_q == KeyPressed) && act &&
                      (hold_thresh_i != '0) && (cnt_inc >= hold_thresh_i);

  assign cnt_inc_en = down && act;

  always_comb begin
    status_set             = '0;
    status_set[StPress]    = ev_press;
    status_set[StRelease]  = ev_release;
    status_set[StHold]     = ev_hold;
  end

  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = KeyDisarmed;
    end else begin
      case (state_q)
        KeyDisarmed: if (!act) state_d = KeyIdle;
        KeyIdle:     if (act) state_d = KeyPressed;
        KeyPressed: begin
          if (!act)         state_d = KeyIdle;
          else if (ev_hold) state_d = KeyHeld;
        end
        KeyHeld:     if (!act) state_d = KeyIdle;
        default:     state_d = KeyDisarmed;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= KeyDisarmed;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      hold_o    <= 1'b0;
      pressed_o <= 1'b0;
      status_o  <= '0;
    end else begin
      state_q   <= state_d;
      press_o   <= ev_press;
      release_o <= ev_release;
      hold_o    <= ev_hold;
      pressed_o <= (state_d == KeyPressed) || (state_d == KeyHeld);
      // Sticky bits freeze while disabled; set wins over a same-cycle clear.
      if (enable_i) begin
        status_o <= (status_o & ~status_clr_i) | status_set;
      end
    end
  end

  prim_sat_counter #(
    .Width(CntW)
  ) u_hold_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (!cnt_inc_en),
    .inc_i    (cnt_inc_en),
    .cnt_o    (hold_cnt_o),
    .cnt_inc_o(cnt_inc)
  );

endmodule

// File: tb/tb_prim_key_event_detect.sv
// Scoreboard bench: two detector builds (16-bit active-high, 4-bit active-low)
// driven with the same logical key activity and checked against a flag-based model.
module tb_prim_key_event_detect;

  typedef struct packed {
    logic        press;
    logic        rel;
    logic        hold;
    logic        pressed;
    logic [15:0] cnt;
    logic [2:0]  st;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        lvl = 1'b0;
  logic        lvl_n;
  logic [15:0] thresh = '0;
  logic [3:0]  thresh_lo;
  logic [2:0]  clr = '0;

  logic        press_h, rel_h, hold_h, prs_h;
  logic [15:0] cnt_h;
  logic [2:0]  st_h;
  logic        press_l, rel_l, hold_l, prs_l;
  logic [3:0]  cnt_l;
  logic [2:0]  st_l;

  int checks = 0;
  int errors = 0;

  obs_t q_hi[$];
  obs_t q_lo[$];

  bit       m_armed[2];
  bit       m_down[2];
  bit       m_held[2];
  int       m_cnt[2];
  logic [2:0] m_st[2];

  assign lvl_n     = ~lvl;
  assign thresh_lo = thresh[3:0];

  always #5 clk = ~clk;

  prim_key_event_detect #(.CntW(16), .ActiveHigh(1'b1)) u_hi (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .level_i(lvl),
    .hold_thresh_i(thresh), .status_clr_i(clr),
    .press_o(press_h), .release_o(rel_h), .hold_o(hold_h),
    .pressed_o(prs_h), .hold_cnt_o(cnt_h), .status_o(st_h)
  );

  prim_key_event_detect #(.CntW(4), .ActiveHigh(1'b0)) u_lo (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .level_i(lvl_n),
    .hold_thresh_i(thresh_lo), .status_clr_i(clr),
    .press_o(press_l), .release_o(rel_l), .hold_o(hold_l),
    .pressed_o(prs_l), .hold_cnt_o(cnt_l), .status_o(st_l)
  );

  // Reference: armed / down / held flags and an integer press duration.
  task automatic model_step(input int d, input bit r, input bit e, input bit a,
                            input int th, input logic [2:0] c, input int maxc,
                            output obs_t o);
    bit p, rl, h;
    p = 0; rl = 0; h = 0;
    if (r) begin
      m_armed[d] = 0; m_down[d] = 0; m_held[d] = 0; m_cnt[d] = 0; m_st[d] = '0;
    end else if (!e) begin
      m_armed[d] = 0; m_down[d] = 0; m_held[d] = 0; m_cnt[d] = 0;
    end else begin
      if (!m_armed[d]) begin
        if (!a) m_armed[d] = 1;
      end else if (!m_down[d]) begin
        if (a) begin m_down[d] = 1; m_cnt[d] = 0; p = 1; end
      end else if (!a) begin
        m_down[d] = 0; m_held[d] = 0; m_cnt[d] = 0; rl = 1;
      end else begin
        m_cnt[d] = (m_cnt[d] < maxc) ? m_cnt[d] + 1 : maxc;
        if (!m_held[d] && th != 0 && m_cnt[d] >= th) begin
          m_held[d] = 1; h = 1;
        end
      end
      m_st[d] = (m_st[d] & ~c) | {h, rl, p};
    end
    o = '{press: p, rel: rl, hold: h, pressed: m_down[d], cnt: 16'(m_cnt[d]), st: m_st[d]};
  endtask

  task automatic drive(input bit r, input bit e, input bit l, input int th, input logic [2:0] c);
    obs_t o;
    @(negedge clk);
    rst = r; en = e; lvl = l; thresh = 16'(th); clr = c;
    model_step(0, r, e, l, th & 16'hffff, c, 65535, o);
    q_hi.push_back(o);
    model_step(1, r, e, l, th & 15, c, 15, o);
    q_lo.push_back(o);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every clock the DUTs present a full output set; compare with the oldest prediction.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (q_hi.size() > 0) begin
        e = q_hi.pop_front();
        a = '{press: press_h, rel: rel_h, hold: hold_h, pressed: prs_h, cnt: cnt_h, st: st_h};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL hi_outputs: got %h expected %h at %0t", a, e, $time);
        end
      end
      if (q_lo.size() > 0) begin
        e = q_lo.pop_front();
        a = '{press: press_l, rel: rel_l, hold: hold_l, pressed: prs_l, cnt: {12'b0, cnt_l}, st: st_l};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL lo_outputs: got %h expected %h at %0t", a, e, $time);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int th;
    bit l;
    bit e;
    logic [2:0] c;

    // Reset with an already-active level, then no arming while it stays active.
    repeat (2) drive(1, 1, 1, 5, 3'b000);
    repeat (4) drive(0, 1, 1, 5, 3'b000);
    check("reset_outputs_hi", {press_h, rel_h, hold_h, prs_h, cnt_h, st_h}, '0);
    check("no_press_unarmed_lo", {press_l, prs_l, st_l}, '0);
    drive(0, 1, 0, 5, 3'b000);
    repeat (3) drive(0, 1, 1, 5, 3'b000);
    drive(0, 1, 1, 5, 3'b000);
    check("press_latched_hi", {prs_h, st_h}, {1'b1, 3'b001});

    // Hold timing with threshold 5, then release.
    drive(0, 1, 0, 5, 3'b000);
    repeat (3) drive(0, 1, 0, 5, 3'b111);
    repeat (10) drive(0, 1, 1, 5, 3'b000);
    repeat (3) drive(0, 1, 0, 5, 3'b000);
    check("after_hold_release_hi", {prs_h, cnt_h, st_h}, {1'b0, 16'd0, 3'b111});

    // Short press: exactly 5 active edges, hold must lose to release.
    drive(0, 1, 0, 5, 3'b111);
    repeat (5) drive(0, 1, 1, 5, 3'b000);
    repeat (3) drive(0, 1, 0, 5, 3'b000);
    check("short_press_status_hi", 32'(st_h), 32'(3'b011));
    check("short_press_status_lo", 32'(st_l), 32'(3'b011));

    // Threshold disabled, long press saturates the 4-bit counter.
    drive(0, 1, 0, 0, 3'b111);
    repeat (40) drive(0, 1, 1, 0, 3'b000);
    check("saturate_lo", {hold_l, cnt_l, st_l[2]}, {1'b0, 4'hf, 1'b0});
    repeat (2) drive(0, 1, 0, 0, 3'b000);

    // Status set/clear collision on the press edge, then a later clear.
    drive(0, 1, 0, 3, 3'b111);
    drive(0, 1, 1, 3, 3'b001);
    drive(0, 1, 1, 3, 3'b000);
    check("set_wins_hi", 32'(st_h[0]), 32'd1);
    drive(0, 1, 1, 3, 3'b001);
    drive(0, 1, 1, 3, 3'b000);
    check("clear_later_hi", 32'(st_h[0]), 32'd0);

    // Disable while held; re-enable with the key still down must not press.
    repeat (5) drive(0, 1, 1, 3, 3'b000);
    drive(0, 0, 1, 3, 3'b000);
    repeat (4) drive(0, 1, 1, 3, 3'b000);
    check("no_press_after_reenable_lo", {prs_l, press_l}, 2'b00);
    drive(0, 1, 0, 3, 3'b000);
    repeat (3) drive(0, 1, 1, 3, 3'b000);
    drive(0, 1, 1, 3, 3'b000);
    check("press_after_rearm_lo", 32'(prs_l), 32'd1);
    // Reset mid-press: no release, must re-arm.
    drive(1, 1, 1, 3, 3'b000);
    repeat (3) drive(0, 1, 1, 3, 3'b000);

    // Randomized activity.
    th = 4; l = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) l = ~l;
      if ($urandom_range(99) == 0) th = $urandom_range(20);
      e = ($urandom_range(47) != 0);
      c = (e && $urandom_range(11) == 0) ? 3'($urandom) : 3'b000;
      drive($urandom_range(299) == 0, e, l, th, c);
    end

    for (int i = 0; i < 5 && (q_hi.size() > 0 || q_lo.size() > 0); i++) @(negedge clk);
    check("scoreboard_drained", 32'(q_hi.size() + q_lo.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
